io_bus_responder: RTL

- Memory-mapped I/O responder on the LEGLite single-cycle CPU data bus: the target side of the CPU's draddr/dwdata/dwrite/dread/drdata interface for a small I/O window.
- Synchronises the two board switches and latches their rising edges.
- Holds the display nibble and drives the 7-segment output.
- Runs a prescaled free-running timer.
- The data-memory wrapper ORs drdata with the RAM read data, gated by io_hit.

---
 rtl/io_bus_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/io_bus_responder.sv
// Purpose : memory-mapped I/O target on the CPU data bus (switches, edge latch, 7-seg nibble, timer).
// Latency : reads are combinational (zero cycles); writes land on the rising clock edge.
// Backpressure: none, every bus access completes in its own cycle.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   draddr/dwdata          bus address and write data
//   dwrite/dread           write strobe (edge-sampled), read strobe
//   drdata/io_hit          combinational read data and window-hit flag
//   io_sw0/io_sw1          asynchronous board switches
//   io_display             7-segment drive {g,f,e,d,c,b,a}, active-high
module io_bus_responder #(
  parameter logic [15:0] IO_BASE  = 16'hFFF0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] draddr,
  input  logic [15:0] dwdata,
  input  logic        dwrite,
  input  logic        dread,
  output logic [15:0] drdata,
  output logic        io_hit,
  input  logic        io_sw0,
  input  logic        io_sw1,
  output logic [6:0]  io_display
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  // Address decode: exact match only, so odd addresses never hit.
  logic sel_sw, sel_edge, sel_disp, sel_timer;
  assign sel_sw    = (draddr == IO_BASE);
  assign sel_edge  = (draddr == IO_BASE + 16'd2);
  assign sel_disp  = (draddr == IO_BASE + 16'd4);
  assign sel_timer = (draddr == IO_BASE + 16'd6);
  assign io_hit    = sel_sw | sel_edge | sel_disp | sel_timer;

  logic wr_edge, wr_disp, wr_timer;
  assign wr_edge  = dwrite & sel_edge;
  assign wr_disp  = dwrite & sel_disp;
  assign wr_timer = dwrite & sel_timer;

  logic [1:0]      s1_q, s1_d;
  logic [1:0]      s2_q, s2_d;
  logic [1:0]      prev_q, prev_d;
  logic [1:0]      edge_q, edge_d;
  logic [3:0]      disp_q, disp_d;
  logic [15:0]     timer_q, timer_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    s1_d   = {io_sw1, io_sw0};
    s2_d   = s1_q;
    prev_d = s2_q;

    // Clear first, then OR in new rises so a coincident set wins.
    edge_d = edge_q;
    if (wr_edge) begin
      edge_d = edge_q & ~dwdata[1:0];
    end
    edge_d = edge_d | (s2_q & ~prev_q);

    disp_d = disp_q;
    if (wr_disp) begin
      disp_d = dwdata[3:0];
    end

    // A timer write restarts the prescale period and beats any increment.
    timer_d = timer_q;
    pc_d    = pc_q;
    if (wr_timer) begin
      timer_d = dwdata;
      pc_d    = '0;
    end else if (pc_q == PC_LAST) begin
      timer_d = timer_q + 16'd1;
      pc_d    = '0;
    end else begin
      pc_d    = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      disp_q  <= '0;
      timer_q <= '0;
      pc_q    <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
      disp_q  <= disp_d;
      timer_q <= timer_d;
      pc_q    <= pc_d;
    end
  end

  // Read mux; returns pre-edge state when a write hits the same register.
  always_comb begin
    drdata = 16'h0000;
    if (dread) begin
      if (sel_sw)         drdata = {14'b0, s2_q};
      else if (sel_edge)  drdata = {14'b0, edge_q};
      else if (sel_disp)  drdata = {12'b0, disp_q};
      else if (sel_timer) drdata = timer_q;
    end
  end

  always_comb begin
    io_display = 7'h3F;
    case (disp_q)
      4'h0: io_display = 7'h3F;
      4'h1: io_display = 7'h06;
      4'h2: io_display = 7'h5B;
      4'h3: io_display = 7'h4F;
      4'h4: io_display = 7'h66;
      4'h5: io_display = 7'h6D;
      4'h6: io_display = 7'h7D;
      4'h7: io_display = 7'h07;
      4'h8: io_display = 7'h7F;
      4'h9: io_display = 7'h6F;
      4'hA: io_display = 7'h77;
      4'hB: io_display = 7'h7C;
      4'hC: io_display = 7'h39;
      4'hD: io_display = 7'h5E;
      4'hE: io_display = 7'h79;
      4'hF: io_display = 7'h71;
      default: io_display = 7'h3F;
    endcase
  end

endmodule
